if_fetch_queue: RTL and testbench

Instruction-fetch front end for the 5-stage ARM pipeline. It owns the program counter and issues word reads to the instruction memory over a req/ack handshake. Fetched words go into a 2-entry prefetch queue, together with their PC+4. The queue head feeds the IF/ID register: a valid/ready pop models the hazard unit's IF/ID load-enable, and a redirect port takes branch targets from the condition handler.

---
 rtl/if_fetch_queue.sv | 137 +++++++++++++
 tb/tb_if_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one word read at a time to
// instruction memory, and buffers fetched {inst, pc+4} pairs in a 2-entry queue.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc4,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] fetch_addr_reg, fetch_addr_next;
  logic [1:0]  count_reg, count_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic [31:0] inst_mem [2];
  logic [31:0] pc4_mem  [2];

  logic        ack;
  logic        pop;
  logic        push;
  logic [1:0]  cnt_after_pop;
  logic [31:0] target;

  assign ack           = imem_ack & (state_reg != IDLE);
  assign pop           = out_valid & out_ready;
  assign cnt_after_pop = count_reg - {1'b0, pop};
  assign target        = redirect_target & ~32'h0000_0003;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    fetch_addr_next = fetch_addr_reg;
    count_next      = count_reg;
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    push            = 1'b0;

    if (redirect) begin
      // Flush drops any same-cycle pop and push along with the queued entries.
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
      if (state_reg == IDLE || ack) begin
        fetch_addr_next = target;
        pc_next         = target + 32'd4;
        state_next      = BUSY;
      end else begin
        // Stale request still in flight: let it finish, then refetch from pc.
        pc_next    = target;
        state_next = DROP;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg < 2'd2) begin
            fetch_addr_next = pc_reg;
            pc_next         = pc_reg + 32'd4;
            state_next      = BUSY;
          end
        end
        BUSY: begin
          if (ack) begin
            push = 1'b1;
            if (cnt_after_pop == 2'd0) begin
              fetch_addr_next = pc_reg;
              pc_next         = pc_reg + 32'd4;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DROP: begin
          if (ack) begin
            fetch_addr_next = pc_reg;
            pc_next         = pc_reg + 32'd4;
            state_next      = BUSY;
          end
        end
        default: state_next = IDLE;
      endcase

      if (pop) begin
        rd_ptr_next = ~rd_ptr_reg;
      end
      if (push) begin
        wr_ptr_next = ~wr_ptr_reg;
      end
      count_next = cnt_after_pop + {1'b0, push};
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      fetch_addr_reg <= RESET_PC;
      count_reg      <= 2'd0;
      rd_ptr_reg     <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        inst_mem[i] <= '0;
        pc4_mem[i]  <= '0;
      end
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      fetch_addr_reg <= fetch_addr_next;
      count_reg      <= count_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      if (push) begin
        inst_mem[wr_ptr_reg] <= imem_data;
        pc4_mem[wr_ptr_reg]  <= fetch_addr_reg + 32'd4;
      end
    end
  end

  assign imem_req  = (state_reg != IDLE);
  assign imem_addr = fetch_addr_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_inst  = out_valid ? inst_mem[rd_ptr_reg] : 32'd0;
  assign out_pc4   = out_valid ? pc4_mem[rd_ptr_reg]  : 32'd0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, back-pressure, wait states,
// redirects (idle and mid-wait), address wrap and mid-fetch reset.
module tb_if_fetch_queue;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  int tests_run = 0;
  int tests_failed = 0;
  int wait_n = 0;
  int busy_cycles = 0;
  logic clr_s;
  logic ack_s;

  if_fetch_queue #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .out_valid(out_valid),
    .out_inst(out_inst),
    .out_pc4(out_pc4),
    .out_ready(out_ready),
    .redirect(redirect),
    .redirect_target(redirect_target)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 + {2'b00, a[31:2]};
  endfunction

  // Memory responder: acks after wait_n idle cycles of an outstanding request.
  always @(posedge CLK) begin
    clr_s = CLR;
    ack_s = imem_ack;
    #1;
    if (clr_s || !imem_req) begin
      imem_ack    = 1'b0;
      busy_cycles = 0;
    end else begin
      if (ack_s) busy_cycles = 0;
      imem_ack  = (busy_cycles == wait_n);
      imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      busy_cycles++;
    end
  end

  always @(posedge CLK) begin
    if (!CLR && !redirect && out_valid && out_ready)
      $display("[TB] pop inst=%h pc4=%h", out_inst, out_pc4);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [31:0] inst,
                             input logic [31:0] pc4);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_pc4"}, out_pc4, pc4);
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
    check({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic do_reset(input int waits);
    wait_n = waits;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1;
    out_ready = 1'b1;
    redirect = 1'b0;
    redirect_target = 32'd0;
    wait_n = 0;

    // Reset and zero-wait streaming
    tick();
    tick();
    expect_head("rst", 1'b0, 32'd0, 32'd0);
    expect_req("rst", 1'b0, 32'd0);
    CLR = 1'b0;
    tick();
    expect_head("e1", 1'b0, 32'd0, 32'd0);
    expect_req("e1", 1'b1, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_head("stream", 1'b1, mem_word(32'(4 * k)), 32'(4 * k + 4));
    end

    // Back-pressure: queue fills to 2, fetch stops, order preserved on release
    out_ready = 1'b0;
    tick();
    expect_req("bp_full", 1'b0, 32'h18);
    expect_head("bp_full", 1'b1, mem_word(32'h14), 32'h18);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_req("bp_hold", 1'b0, 32'h18);
      expect_head("bp_hold", 1'b1, mem_word(32'h14), 32'h18);
    end
    out_ready = 1'b1;
    tick();
    expect_head("bp_rel1", 1'b1, mem_word(32'h18), 32'h1C);
    expect_req("bp_rel1", 1'b0, 32'h18);
    tick();
    expect_head("bp_rel2", 1'b0, 32'd0, 32'd0);
    expect_req("bp_rel2", 1'b1, 32'h1C);
    tick();
    expect_head("bp_rel3", 1'b1, mem_word(32'h1C), 32'h20);
    tick();
    expect_head("bp_rel4", 1'b1, mem_word(32'h20), 32'h24);

    // Three wait states: one instruction every four cycles, address held
    do_reset(3);
    out_ready = 1'b1;
    tick();
    expect_req("ws_e1", 1'b1, 32'd0);
    for (int j = 0; j < 3; j++) begin
      for (int w = 0; w < 3; w++) begin
        tick();
        expect_req("ws_wait", 1'b1, 32'(4 * j));
        check("ws_wait_valid", {31'd0, out_valid}, 32'd0);
      end
      tick();
      expect_head("ws_push", 1'b1, mem_word(32'(4 * j)), 32'(4 * j + 4));
    end

    // Redirect from IDLE with a full queue and a same-cycle pop
    do_reset(0);
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    expect_head("rdi_full", 1'b1, mem_word(32'h0), 32'h4);
    expect_req("rdi_full", 1'b0, 32'h4);
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    expect_head("rdi_flush", 1'b0, 32'd0, 32'd0);
    expect_req("rdi_flush", 1'b1, 32'h100);
    tick();
    expect_head("rdi_tgt", 1'b1, mem_word(32'h100), 32'h104);
    tick();
    expect_head("rdi_tgt2", 1'b1, mem_word(32'h104), 32'h108);

    // Redirect mid-wait, then a second redirect while dropping
    do_reset(3);
    out_ready = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    expect_req("rdw_drop", 1'b1, 32'd0);
    check("rdw_drop_valid", {31'd0, out_valid}, 32'd0);
    redirect = 1'b1;
    redirect_target = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    expect_req("rdw_drop2", 1'b1, 32'd0);
    tick();
    expect_req("rdw_drop3", 1'b1, 32'd0);
    tick();
    expect_req("rdw_refetch", 1'b1, 32'h300);
    check("rdw_stale_valid", {31'd0, out_valid}, 32'd0);
    for (int w = 0; w < 3; w++) begin
      tick();
      expect_req("rdw_wait", 1'b1, 32'h300);
      check("rdw_wait_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    expect_head("rdw_tgt", 1'b1, mem_word(32'h300), 32'h304);

    // Address wrap, then reset while a request is outstanding
    do_reset(0);
    out_ready = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    expect_req("wrap_addr", 1'b1, 32'hFFFF_FFFC);
    check("wrap_flush_valid", {31'd0, out_valid}, 32'd0);
    tick();
    expect_head("wrap_head", 1'b1, mem_word(32'hFFFF_FFFC), 32'd0);
    expect_req("wrap_next", 1'b1, 32'd0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    expect_head("midrst", 1'b0, 32'd0, 32'd0);
    expect_req("midrst", 1'b0, 32'd0);
    tick();
    expect_req("midrst_e1", 1'b1, 32'd0);
    tick();
    expect_head("midrst_e2", 1'b1, mem_word(32'd0), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
